// File: rtl/operand_select_stage.sv
// Registered ALU operand-select stage with priority forwarding, a valid/ready
// handshake and a two-entry skid buffer. One cycle from accept to OUT_VALID.
module operand_select_stage #(
  parameter int WIDTH = 32,
  parameter int N_FWD = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [WIDTH-1:0]       PC_M1,
  input  logic [WIDTH-1:0]       A_DATA,
  input  logic [WIDTH-1:0]       B_DATA,
  input  logic [WIDTH-1:0]       SEorZF,
  input  logic                   MA,
  input  logic                   MB,
  input  logic [N_FWD*WIDTH-1:0] FWD_DATA,
  input  logic [N_FWD-1:0]       FWD_A_HIT,
  input  logic [N_FWD-1:0]       FWD_B_HIT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [WIDTH-1:0]       BUS_A,
  output logic [WIDTH-1:0]       BUS_B
);

  // state    | meaning
  // ST_EMPTY | no entry held
  // ST_FULL  | output register valid, skid empty
  // ST_SKID  | output register and skid both valid, upstream stalled
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t           state, state_nxt;
  logic             in_ready_q;
  logic [WIDTH-1:0] bus_a_q, bus_b_q, skid_a_q, skid_b_q;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             accept, drain;
  logic             load_out_sel, load_out_skid, load_skid;

  // Walk from the highest index down so the lowest hitting source wins.
  always_comb begin
    a_sel = A_DATA;
    b_sel = B_DATA;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (FWD_A_HIT[i]) a_sel = FWD_DATA[i*WIDTH +: WIDTH];
      if (FWD_B_HIT[i]) b_sel = FWD_DATA[i*WIDTH +: WIDTH];
    end
    if (MA) a_sel = PC_M1;
    if (MB) b_sel = SEorZF;
  end

  assign accept = IN_VALID & in_ready_q;
  assign drain  = OUT_VALID & OUT_READY;

  always_comb begin
    state_nxt     = state;
    load_out_sel  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_FULL;
          load_out_sel = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && drain) begin
          load_out_sel = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end else if (accept) begin
          state_nxt = ST_SKID;
          load_skid = 1'b1;
        end
      end
      ST_SKID: begin
        if (drain) begin
          state_nxt     = ST_FULL;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
      bus_a_q    <= '0;
      bus_b_q    <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
    end else if (FLUSH) begin
      // Bus contents are left as-is; they are meaningless while OUT_VALID is low.
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_SKID);
      if (load_out_sel) begin
        bus_a_q <= a_sel;
        bus_b_q <= b_sel;
      end else if (load_out_skid) begin
        bus_a_q <= skid_a_q;
        bus_b_q <= skid_b_q;
      end
      if (load_skid) begin
        skid_a_q <= a_sel;
        skid_b_q <= b_sel;
      end
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state != ST_EMPTY);
  assign BUS_A     = bus_a_q;
  assign BUS_B     = bus_b_q;

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed, table-driven bench for operand_select_stage: select/forwarding
// vectors plus hand sequences for backpressure, throughput, flush and reset.
module tb_operand_select_stage;

  localparam int WIDTH = 32;
  localparam int N_FWD = 2;

  logic                   CLK = 1'b0;
  logic                   RESET, FLUSH, IN_VALID, IN_READY;
  logic [WIDTH-1:0]       PC_M1, A_DATA, B_DATA, SEorZF;
  logic                   MA, MB;
  logic [N_FWD*WIDTH-1:0] FWD_DATA;
  logic [N_FWD-1:0]       FWD_A_HIT, FWD_B_HIT;
  logic                   OUT_VALID, OUT_READY;
  logic [WIDTH-1:0]       BUS_A, BUS_B;

  int checks = 0;
  int errors = 0;
  int drains = 0;

  operand_select_stage #(.WIDTH(WIDTH), .N_FWD(N_FWD)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .PC_M1(PC_M1), .A_DATA(A_DATA), .B_DATA(B_DATA), .SEorZF(SEorZF),
    .MA(MA), .MB(MB), .FWD_DATA(FWD_DATA),
    .FWD_A_HIT(FWD_A_HIT), .FWD_B_HIT(FWD_B_HIT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUS_A(BUS_A), .BUS_B(BUS_B)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ma, mb;
    logic [31:0] pc, a, b, se;
    logic [63:0] fwd;
    logic [1:0]  ha, hb;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Plain A/B operands with no forwarding, B tagged as A+0x100.
  task automatic offer(input logic [31:0] val);
    MA = 1'b0; MB = 1'b0; FWD_A_HIT = '0; FWD_B_HIT = '0;
    A_DATA = val; B_DATA = val + 32'h100;
  endtask

  initial begin
    vecs[0] = '{ma:1, mb:1, pc:32'h40,  a:32'h11, b:32'h22, se:32'hFFFF_FFF0,
                fwd:{32'hBB, 32'hAA}, ha:2'b00, hb:2'b00, ea:32'h40, eb:32'hFFFF_FFF0};
    vecs[1] = '{ma:0, mb:0, pc:32'h40,  a:32'h5,  b:32'h7,  se:32'h99,
                fwd:{32'hBB, 32'hAA}, ha:2'b00, hb:2'b00, ea:32'h5,  eb:32'h7};
    vecs[2] = '{ma:0, mb:0, pc:32'h40,  a:32'h5,  b:32'h7,  se:32'h99,
                fwd:{32'hBB, 32'hAA}, ha:2'b11, hb:2'b10, ea:32'hAA, eb:32'hBB};
    vecs[3] = '{ma:1, mb:1, pc:32'h100, a:32'h5,  b:32'h7,  se:32'h200,
                fwd:{32'hBB, 32'hAA}, ha:2'b11, hb:2'b10, ea:32'h100, eb:32'h200};
    vecs[4] = '{ma:0, mb:0, pc:32'h100, a:32'h5,  b:32'h7,  se:32'h200,
                fwd:{32'hDEAD_0001, 32'hCAFE_0000}, ha:2'b10, hb:2'b01,
                ea:32'hDEAD_0001, eb:32'hCAFE_0000};
    vecs[5] = '{ma:1, mb:0, pc:32'h8000_0000, a:32'h5, b:32'h1234_5678, se:32'h200,
                fwd:{32'hBB, 32'hAA}, ha:2'b01, hb:2'b00, ea:32'h8000_0000, eb:32'h1234_5678};

    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    PC_M1 = '0; A_DATA = '0; B_DATA = '0; SEorZF = '0; MA = 1'b0; MB = 1'b0;
    FWD_DATA = '0; FWD_A_HIT = '0; FWD_B_HIT = '0;

    tick(); tick();
    check("reset_out_valid", 32'(OUT_VALID), 32'd0);
    check("reset_bus_a", BUS_A, 32'h0);
    check("reset_bus_b", BUS_B, 32'h0);
    check("reset_in_ready", 32'(IN_READY), 32'd0);
    RESET = 1'b0;
    tick();
    check("post_reset_in_ready", 32'(IN_READY), 32'd1);

    // Select / forwarding table, one entry in flight at a time.
    foreach (vecs[k]) begin
      MA = vecs[k].ma; MB = vecs[k].mb; PC_M1 = vecs[k].pc; A_DATA = vecs[k].a;
      B_DATA = vecs[k].b; SEorZF = vecs[k].se; FWD_DATA = vecs[k].fwd;
      FWD_A_HIT = vecs[k].ha; FWD_B_HIT = vecs[k].hb;
      IN_VALID = 1'b1; OUT_READY = 1'b0;
      tick();
      IN_VALID = 1'b0;
      check($sformatf("vec%0d_valid", k), 32'(OUT_VALID), 32'd1);
      check($sformatf("vec%0d_bus_a", k), BUS_A, vecs[k].ea);
      check($sformatf("vec%0d_bus_b", k), BUS_B, vecs[k].eb);
      OUT_READY = 1'b1;
      tick();
      check($sformatf("vec%0d_drained", k), 32'(OUT_VALID), 32'd0);
    end

    // Backpressure: 1 on bus, 2 in skid, 3 held upstream.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    offer(32'd1); tick();
    check("bp_in_ready_after_1", 32'(IN_READY), 32'd1);
    offer(32'd2); tick();
    check("bp_in_ready_skid", 32'(IN_READY), 32'd0);
    offer(32'd3); tick(); tick();
    check("bp_hold_bus_a", BUS_A, 32'd1);
    check("bp_hold_bus_b", BUS_B, 32'h101);
    check("bp_hold_in_ready", 32'(IN_READY), 32'd0);
    OUT_READY = 1'b1;
    tick();
    check("bp_second_bus_a", BUS_A, 32'd2);
    check("bp_second_bus_b", BUS_B, 32'h102);
    check("bp_second_in_ready", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("bp_third_bus_a", BUS_A, 32'd3);
    check("bp_third_valid", 32'(OUT_VALID), 32'd1);
    tick();
    check("bp_empty", 32'(OUT_VALID), 32'd0);

    // Full throughput: one accept and one drain per cycle.
    drains = 0;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(32'd10 + 32'(i));
      tick();
      check($sformatf("tp%0d_in_ready", i), 32'(IN_READY), 32'd1);
      check($sformatf("tp%0d_bus_a", i), BUS_A, 32'd10 + 32'(i));
      if (OUT_VALID && OUT_READY) drains++;
    end
    IN_VALID = 1'b0;
    tick();
    check("tp_empty", 32'(OUT_VALID), 32'd0);
    check("tp_drain_count", 32'(drains), 32'd8);

    // Flush in SKID with a new entry offered in the same cycle.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    offer(32'h50); tick();
    offer(32'h51); tick();
    check("fl_pre_in_ready", 32'(IN_READY), 32'd0);
    offer(32'h52); FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check("fl_out_valid", 32'(OUT_VALID), 32'd0);
    check("fl_in_ready", 32'(IN_READY), 32'd1);
    OUT_READY = 1'b1;
    tick();
    check("fl_still_empty", 32'(OUT_VALID), 32'd0);
    offer(32'h60); IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check("fl_next_bus_a", BUS_A, 32'h60);
    check("fl_next_valid", 32'(OUT_VALID), 32'd1);
    tick();
    check("fl_no_resurrect", 32'(OUT_VALID), 32'd0);

    // Reset while SKID is occupied drops both entries.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    offer(32'h70); tick();
    offer(32'h71); tick();
    IN_VALID = 1'b0; RESET = 1'b1;
    tick();
    check("rs_mid_valid", 32'(OUT_VALID), 32'd0);
    check("rs_mid_bus_a", BUS_A, 32'h0);
    check("rs_mid_in_ready", 32'(IN_READY), 32'd0);
    RESET = 1'b0; OUT_READY = 1'b1;
    tick();
    check("rs_after_in_ready", 32'(IN_READY), 32'd1);
    check("rs_after_valid", 32'(OUT_VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
